// File: rtl/uart_rx.sv
// uart_rx -- 8N1 serial receiver, LSB first, with overrun and frame-error
// reporting toward an I/O arbiter.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (4..65535)
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous, active-high
//   rx          asynchronous serial line, idle high
//   rxAck       one-cycle pulse: current byte consumed
//   data        last correctly framed byte, stable while readyRx=1
//   readyRx     level: byte available
//   frameError  one-cycle pulse: stop bit sampled low
//   overrun     sticky: a byte was dropped because readyRx was still set
//   busy        receiver is not idle (combinational from state)
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  input  logic       rxAck,
  output logic [7:0] data,
  output logic       readyRx,
  output logic       frameError,
  output logic       overrun,
  output logic       busy
);

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic        rx_meta;
  logic        rx_s;

  // A good stop bit this cycle; an rxAck arriving now must not clear the
  // flags, because the new byte takes its place instead.
  logic stop_hit;
  logic complete;

  assign stop_hit = (state == STOP) && (cnt == FULL_M1);
  assign complete = stop_hit && rx_s;
  assign busy     = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      // Synchronizer resets to the idle line level so no false start
      // is seen right after reset.
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      data       <= '0;
      readyRx    <= 1'b0;
      frameError <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      frameError <= 1'b0;

      if (rxAck && readyRx && !complete) begin
        readyRx <= 1'b0;
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end

        // Re-check the line at mid start bit to reject glitches.
        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        DATA: begin
          if (cnt == FULL_M1) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              if (!readyRx || rxAck) begin
                data    <= shreg;
                readyRx <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frameError <= 1'b1;
              state      <= BREAK;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        // Line held low after a bad stop: wait for idle so a break
        // condition yields a single frame error.
        BREAK: begin
          if (rx_s) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have port: clock  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: rx  input  1  asynchronous serial line; idle high; 8N1 format, LSB first.
REQ-005 SHALL have port: rxAck  input  1  one-cycle pulse from the I/O arbiter; the current byte has been consumed.
REQ-006 SHALL have port: data  output  8  last correctly framed byte; stable while readyRx=1.
REQ-007 SHALL have port: readyRx  output  1  byte available; level signal feeding the arbiter's readyRx0/readyRx1 input.
REQ-008 SHALL have port: frameError  output  1  one-cycle pulse; stop bit sampled low.
REQ-009 SHALL have port: overrun  output  1  sticky flag; a byte was lost because readyRx was still set.
REQ-010 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-011 SHALL have exactly one clock, clock; reset SHALL be synchronous and active-high.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; all decoding SHALL use the synchronized value rxS, giving 2 cycles of input latency.
REQ-013 The state machine SHALL have states IDLE, START, DATA, STOP, BREAK, with a 16-bit cycle counter cnt and a 3-bit bit index idx.
REQ-014 IDLE: when rxS=0, go to START with cnt=0; otherwise remain in IDLE.
REQ-015 START: increment cnt; when cnt=CLKS_PER_BIT/2-1 (integer division), sample rxS.
- rxS=0: go to DATA with cnt=0 and idx=0.
- rxS=1: glitch; return to IDLE with no output change.
REQ-016 DATA: increment cnt; when cnt=CLKS_PER_BIT-1, shift rxS into bit idx of the shift register and set cnt=0.
- idx=7: go to STOP.
- otherwise: increment idx.
REQ-017 STOP: when cnt=CLKS_PER_BIT-1, sample rxS.
- rxS=1: complete the byte per REQ-018/019, then go to IDLE.
- rxS=0: pulse frameError for exactly 1 cycle, leave data/readyRx/overrun unchanged, go to BREAK.
REQ-018 Byte completion with readyRx=0, or with rxAck=1 in the same cycle: data<=shift register and readyRx<=1 on the next edge; overrun unchanged.
REQ-019 Byte completion with readyRx=1 and rxAck=0: discard the new byte, keep data, set overrun<=1.
REQ-020 BREAK: remain until rxS=1, then go to IDLE; a line held low SHALL NOT produce repeated frames.
REQ-021 rxAck while readyRx=1 and no completion in that cycle: readyRx<=0 and overrun<=0 on the next edge.
REQ-022 rxAck while readyRx=0 SHALL be ignored.
REQ-023 data SHALL change only on a successful completion per REQ-018.
REQ-024 Latency: readyRx rises 1 cycle after the stop-bit sample cycle; the stop-bit sample occurs (9.5 x CLKS_PER_BIT, rounded down) cycles after the first cycle with rxS=0.
REQ-025 busy SHALL be combinational from the state register (state != IDLE).

Reset
REQ-026 reset=1 at any clock edge SHALL force state=IDLE, cnt=0, idx=0, shift register=0, data=8'h00, readyRx=0, frameError=0, overrun=0.
REQ-027 Both synchronizer flops SHALL reset to 1 (line idle).
REQ-028 Reset asserted mid-frame SHALL abort the frame with no readyRx or frameError pulse.
REQ-029 After reset is released, the block SHALL wait for a high-to-low edge on rxS before starting a frame.

Verification (CLKS_PER_BIT=8)
REQ-030 Serialize 8'hA5 with valid stop bit -> readyRx=1, data=8'hA5, frameError=0, overrun=0; rxAck pulse -> readyRx=0 next cycle.
REQ-031 Send 8'h3C, then 8'hC3 without any rxAck -> data=8'h3C, readyRx=1, overrun=1; rxAck -> readyRx=0, overrun=0.
REQ-032 Send 8'hFF with stop bit driven low -> frameError high for exactly 1 cycle, readyRx=0, state=BREAK while rx stays low; rx high then 8'h01 -> data=8'h01.
REQ-033 Drive rx low for 3 cycles, then high (glitch) -> return to IDLE, readyRx=0, busy drops within 6 cycles.
REQ-034 Assert rxAck in the same cycle that 8'h5A completes while 8'h11 is pending -> data=8'h5A, readyRx=1, overrun=0.
REQ-035 Assert reset during data bit 4 of 8'h77 -> all outputs at reset values; a following 8'h22 is received correctly.
